// File: rtl/dest_pipe_tracker.sv
// Carries write-back destination/enable from ID through EXE, MEM and WB, inserting
// bubbles on hazard/branch, holding on memory freeze, and tracking stall statistics.
module dest_pipe_tracker #(
   parameter int REG_ADDR_LEN  = 4,
   parameter int STALL_CNT_LEN = 16,
   parameter int MAX_STALL     = 2
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     hazard,
   input  logic                     branch_taken,
   input  logic                     mem_freeze,
   input  logic                     id_valid,
   input  logic [REG_ADDR_LEN-1:0]  id_dest,
   input  logic                     id_wb_en,
   output logic                     pc_freeze,
   output logic                     if_id_freeze,
   output logic                     if_id_flush,
   output logic [REG_ADDR_LEN-1:0]  exe_dest,
   output logic                     exe_wb_en,
   output logic [REG_ADDR_LEN-1:0]  mem_dest,
   output logic                     mem_wb_en,
   output logic [REG_ADDR_LEN-1:0]  wb_dest,
   output logic                     wb_wb_en,
   output logic [1:0]               state,
   output logic [STALL_CNT_LEN-1:0] stall_count,
   output logic                     deadlock
);

   typedef enum logic [1:0] {
      ST_RUN    = 2'd0,
      ST_STALL  = 2'd1,
      ST_FROZEN = 2'd2,
      ST_FLUSH  = 2'd3
   } state_t;

   // Run counter only needs to reach one past MAX_STALL; it saturates there.
   localparam int RUN_W = (MAX_STALL + 2 > 2) ? $clog2(MAX_STALL + 2) : 1;
   localparam logic [RUN_W-1:0] RUN_SAT = RUN_W'(MAX_STALL + 1);

   logic [REG_ADDR_LEN-1:0]  exe_dest_q, exe_dest_d;
   logic                     exe_wb_en_q, exe_wb_en_d;
   logic [REG_ADDR_LEN-1:0]  mem_dest_q, mem_dest_d;
   logic                     mem_wb_en_q, mem_wb_en_d;
   logic [REG_ADDR_LEN-1:0]  wb_dest_q, wb_dest_d;
   logic                     wb_wb_en_q, wb_wb_en_d;
   state_t                   state_q, state_d;
   logic [STALL_CNT_LEN-1:0] stall_cnt_q, stall_cnt_d;
   logic [RUN_W-1:0]         run_q, run_d;
   logic                     deadlock_q, deadlock_d;

   always_comb begin
      exe_dest_d  = exe_dest_q;
      exe_wb_en_d = exe_wb_en_q;
      mem_dest_d  = mem_dest_q;
      mem_wb_en_d = mem_wb_en_q;
      wb_dest_d   = wb_dest_q;
      wb_wb_en_d  = wb_wb_en_q;
      state_d     = state_q;
      stall_cnt_d = stall_cnt_q;
      run_d       = run_q;
      deadlock_d  = deadlock_q;

      if (mem_freeze) begin
         state_d = ST_FROZEN;
      end else begin
         wb_dest_d   = mem_dest_q;
         wb_wb_en_d  = mem_wb_en_q;
         mem_dest_d  = exe_dest_q;
         mem_wb_en_d = exe_wb_en_q;
         if (branch_taken) begin
            exe_dest_d  = '0;
            exe_wb_en_d = 1'b0;
            state_d     = ST_FLUSH;
            run_d       = '0;
         end else if (hazard) begin
            exe_dest_d  = '0;
            exe_wb_en_d = 1'b0;
            state_d     = ST_STALL;
            if (stall_cnt_q != '1)
               stall_cnt_d = stall_cnt_q + 1'b1;
            if (run_q != RUN_SAT)
               run_d = run_q + 1'b1;
            // Deadlock trips on the stall that pushes the run past MAX_STALL.
            if (run_q >= RUN_W'(MAX_STALL))
               deadlock_d = 1'b1;
         end else begin
            exe_dest_d  = id_dest;
            exe_wb_en_d = id_wb_en & id_valid;
            state_d     = ST_RUN;
            run_d       = '0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         exe_dest_q  <= '0;
         exe_wb_en_q <= 1'b0;
         mem_dest_q  <= '0;
         mem_wb_en_q <= 1'b0;
         wb_dest_q   <= '0;
         wb_wb_en_q  <= 1'b0;
         state_q     <= ST_RUN;
         stall_cnt_q <= '0;
         run_q       <= '0;
         deadlock_q  <= 1'b0;
      end else begin
         exe_dest_q  <= exe_dest_d;
         exe_wb_en_q <= exe_wb_en_d;
         mem_dest_q  <= mem_dest_d;
         mem_wb_en_q <= mem_wb_en_d;
         wb_dest_q   <= wb_dest_d;
         wb_wb_en_q  <= wb_wb_en_d;
         state_q     <= state_d;
         stall_cnt_q <= stall_cnt_d;
         run_q       <= run_d;
         deadlock_q  <= deadlock_d;
      end
   end

   // A taken branch overrides the hazard stall so the flush can proceed.
   assign pc_freeze    = mem_freeze | (hazard & ~branch_taken);
   assign if_id_freeze = mem_freeze | (hazard & ~branch_taken);
   assign if_id_flush  = branch_taken & ~mem_freeze;

   assign exe_dest    = exe_dest_q;
   assign exe_wb_en   = exe_wb_en_q;
   assign mem_dest    = mem_dest_q;
   assign mem_wb_en   = mem_wb_en_q;
   assign wb_dest     = wb_dest_q;
   assign wb_wb_en    = wb_wb_en_q;
   assign state       = state_q;
   assign stall_count = stall_cnt_q;
   assign deadlock    = deadlock_q;

endmodule

// File: tb/tb_dest_pipe_tracker.sv
// Directed bench for dest_pipe_tracker with a narrow stall counter to reach saturation.
module tb_dest_pipe_tracker;

   logic       clk = 1'b0;
   logic       rst, hazard, branch_taken, mem_freeze, id_valid, id_wb_en;
   logic [3:0] id_dest;
   logic       pc_freeze, if_id_freeze, if_id_flush;
   logic [3:0] exe_dest, mem_dest, wb_dest;
   logic       exe_wb_en, mem_wb_en, wb_wb_en;
   logic [1:0] state;
   logic [3:0] stall_count;
   logic       deadlock;

   int checks = 0;
   int errors = 0;

   dest_pipe_tracker #(.REG_ADDR_LEN(4), .STALL_CNT_LEN(4), .MAX_STALL(2)) dut (
      .clk(clk), .rst(rst), .hazard(hazard), .branch_taken(branch_taken),
      .mem_freeze(mem_freeze), .id_valid(id_valid), .id_dest(id_dest), .id_wb_en(id_wb_en),
      .pc_freeze(pc_freeze), .if_id_freeze(if_id_freeze), .if_id_flush(if_id_flush),
      .exe_dest(exe_dest), .exe_wb_en(exe_wb_en), .mem_dest(mem_dest), .mem_wb_en(mem_wb_en),
      .wb_dest(wb_dest), .wb_wb_en(wb_wb_en), .state(state),
      .stall_count(stall_count), .deadlock(deadlock)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1; hazard = 0; branch_taken = 0; mem_freeze = 0;
      id_valid = 0; id_dest = 4'd0; id_wb_en = 0;
      step(); step();
      rst = 0; #1;
      checks++; if ({exe_dest, exe_wb_en, mem_dest, mem_wb_en, wb_dest, wb_wb_en} !== 15'd0) begin
         errors++; $display("FAIL reset_stages got %h expected 0", {exe_dest, exe_wb_en, mem_dest, mem_wb_en, wb_dest, wb_wb_en}); end
      checks++; if (state !== 2'd0 || stall_count !== 4'd0 || deadlock !== 1'b0) begin
         errors++; $display("FAIL reset_status got state=%0d cnt=%0d dl=%b expected 0/0/0", state, stall_count, deadlock); end
      checks++; if (pc_freeze !== 1'b0 || if_id_flush !== 1'b0) begin
         errors++; $display("FAIL reset_ctrl got pcf=%b flush=%b expected 0/0", pc_freeze, if_id_flush); end
   endtask

   task automatic test_flow();
      logic [3:0] dests [3] = '{4'd3, 4'd5, 4'd7};
      logic [11:0] exp_stages [3] = '{12'h300, 12'h530, 12'h753};
      id_valid = 1; id_wb_en = 1;
      for (int i = 0; i < 3; i++) begin
         id_dest = dests[i];
         step();
         checks++; if ({exe_dest, mem_dest, wb_dest} !== exp_stages[i]) begin
            errors++; $display("FAIL flow_%0d got %h expected %h", i, {exe_dest, mem_dest, wb_dest}, exp_stages[i]); end
      end
      checks++; if ({exe_wb_en, mem_wb_en, wb_wb_en} !== 3'b111 || state !== 2'd0) begin
         errors++; $display("FAIL flow_en got %b st=%0d expected 111 st=0", {exe_wb_en, mem_wb_en, wb_wb_en}, state); end
      id_valid = 0;
      step();
      checks++; if (exe_wb_en !== 1'b0 || mem_dest !== 4'd7 || wb_dest !== 4'd5 || stall_count !== 4'd0) begin
         errors++; $display("FAIL flow_invalid got en=%b mem=%0d wb=%0d cnt=%0d expected 0/7/5/0", exe_wb_en, mem_dest, wb_dest, stall_count); end
   endtask

   task automatic test_hazard();
      int pcf_cycles = 0;
      id_valid = 1; id_wb_en = 1; id_dest = 4'd9; hazard = 1;
      for (int i = 0; i < 2; i++) begin
         #1; if (pc_freeze) pcf_cycles++;
         step();
         checks++; if (exe_wb_en !== 1'b0 || exe_dest !== 4'd0 || state !== 2'd1) begin
            errors++; $display("FAIL hazard_bubble_%0d got en=%b dest=%0d st=%0d expected 0/0/1", i, exe_wb_en, exe_dest, state); end
      end
      hazard = 0;
      #1; if (pc_freeze) pcf_cycles++;
      step();
      checks++; if (exe_dest !== 4'd9 || exe_wb_en !== 1'b1 || state !== 2'd0) begin
         errors++; $display("FAIL hazard_reenter got dest=%0d en=%b st=%0d expected 9/1/0", exe_dest, exe_wb_en, state); end
      checks++; if (pcf_cycles !== 2) begin
         errors++; $display("FAIL hazard_pcf_cycles got %0d expected 2", pcf_cycles); end
      checks++; if (stall_count !== 4'd2 || deadlock !== 1'b0) begin
         errors++; $display("FAIL hazard_count got cnt=%0d dl=%b expected 2/0", stall_count, deadlock); end
   endtask

   task automatic test_deadlock();
      hazard = 1;
      step(); step();
      checks++; if (deadlock !== 1'b0) begin
         errors++; $display("FAIL deadlock_early got %b expected 0", deadlock); end
      step();
      checks++; if (deadlock !== 1'b1) begin
         errors++; $display("FAIL deadlock_set got %b expected 1", deadlock); end
      hazard = 0;
      step(); step();
      checks++; if (deadlock !== 1'b1 || stall_count !== 4'd5) begin
         errors++; $display("FAIL deadlock_sticky got dl=%b cnt=%0d expected 1/5", deadlock, stall_count); end
      rst = 1; step(); rst = 0;
      checks++; if (deadlock !== 1'b0 || stall_count !== 4'd0) begin
         errors++; $display("FAIL deadlock_clear got dl=%b cnt=%0d expected 0/0", deadlock, stall_count); end
   endtask

   task automatic test_freeze();
      id_valid = 1; id_wb_en = 1;
      id_dest = 4'd8; step();
      id_dest = 4'd6; step();
      id_dest = 4'd4; step();
      checks++; if ({exe_dest, mem_dest, wb_dest} !== 12'h468) begin
         errors++; $display("FAIL freeze_fill got %h expected 468", {exe_dest, mem_dest, wb_dest}); end
      mem_freeze = 1; id_dest = 4'd11;
      for (int i = 0; i < 4; i++) begin
         hazard = (i == 1); branch_taken = (i == 2);
         #1;
         checks++; if (pc_freeze !== 1'b1 || if_id_freeze !== 1'b1 || if_id_flush !== 1'b0) begin
            errors++; $display("FAIL freeze_ctrl_%0d got pcf=%b idf=%b fl=%b expected 1/1/0", i, pc_freeze, if_id_freeze, if_id_flush); end
         step();
         checks++; if ({exe_dest, mem_dest, wb_dest} !== 12'h468 || {exe_wb_en, mem_wb_en, wb_wb_en} !== 3'b111
                       || state !== 2'd2 || stall_count !== 4'd0) begin
            errors++; $display("FAIL freeze_hold_%0d got %h en=%b st=%0d cnt=%0d expected 468/111/2/0",
                               i, {exe_dest, mem_dest, wb_dest}, {exe_wb_en, mem_wb_en, wb_wb_en}, state, stall_count); end
      end
      mem_freeze = 0; hazard = 0; branch_taken = 0;
   endtask

   task automatic test_branch();
      branch_taken = 1; hazard = 1; #1;
      checks++; if (if_id_flush !== 1'b1 || pc_freeze !== 1'b0 || if_id_freeze !== 1'b0) begin
         errors++; $display("FAIL branch_ctrl got fl=%b pcf=%b idf=%b expected 1/0/0", if_id_flush, pc_freeze, if_id_freeze); end
      step();
      checks++; if (exe_dest !== 4'd0 || exe_wb_en !== 1'b0 || mem_dest !== 4'd4 || wb_dest !== 4'd6) begin
         errors++; $display("FAIL branch_bubble got exe=%0d/%b mem=%0d wb=%0d expected 0/0 4 6", exe_dest, exe_wb_en, mem_dest, wb_dest); end
      checks++; if (state !== 2'd3 || stall_count !== 4'd0) begin
         errors++; $display("FAIL branch_status got st=%0d cnt=%0d expected 3/0", state, stall_count); end
      branch_taken = 0; hazard = 0;
   endtask

   task automatic test_saturate();
      rst = 1; step(); rst = 0;
      for (int i = 0; i < 15; i++) begin
         hazard = 1; step();
         hazard = 0; step();
      end
      checks++; if (stall_count !== 4'd15 || deadlock !== 1'b0) begin
         errors++; $display("FAIL sat_preload got cnt=%0d dl=%b expected 15/0", stall_count, deadlock); end
      hazard = 1; step(); hazard = 0;
      checks++; if (stall_count !== 4'd15 || state !== 2'd1) begin
         errors++; $display("FAIL sat_hold got cnt=%0d st=%0d expected 15/1", stall_count, state); end
      rst = 1; step(); rst = 0;
      checks++; if (stall_count !== 4'd0 || state !== 2'd0) begin
         errors++; $display("FAIL sat_reset got cnt=%0d st=%0d expected 0/0", stall_count, state); end
   endtask

   initial begin
      test_reset();
      test_flow();
      test_hazard();
      test_deadlock();
      test_freeze();
      test_branch();
      test_saturate();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/dest_pipe_tracker.md
# dest_pipe_tracker

Destination-tracking pipeline for the ARM core's EXE/MEM/WB stages: the producer side of the hazard interface. It carries each instruction's write-back destination and write-enable from ID down through EXE, MEM and WB. It supplies the `exe_dest`/`exe_wb_en`/`mem_dest`/`mem_wb_en` pairs that hazard detection compares against. It also acts on the returned `hazard` stall request, on branch flushes and on memory freezes by inserting bubbles, freezing fetch, and keeping stall statistics and a stall watchdog.

## Interface
Parameters:
- `REG_ADDR_LEN`, default 4: register-file address width.
- `STALL_CNT_LEN`, default 16: width of the stall counter.
- `MAX_STALL`, default 2: the longest legal run of consecutive hazard stalls.

Ports (clock and reset first):
- `clk`, input, 1: single clock.
- `rst`, input, 1: synchronous, active-high reset.
- `hazard`, input, 1: stall request from hazard detection.
- `branch_taken`, input, 1: branch resolved taken in EXE.
- `mem_freeze`, input, 1: memory not ready; freezes the whole pipeline.
- `id_valid`, input, 1: the ID stage holds a real instruction.
- `id_dest`, input, REG_ADDR_LEN: destination register of the ID instruction.
- `id_wb_en`, input, 1: write-back enable of the ID instruction.
- `pc_freeze`, output, 1: hold the PC.
- `if_id_freeze`, output, 1: hold the IF/ID register.
- `if_id_flush`, output, 1: clear the IF/ID register.
- `exe_dest`, output, REG_ADDR_LEN: destination in EXE.
- `exe_wb_en`, output, 1: write-back enable in EXE.
- `mem_dest`, output, REG_ADDR_LEN: destination in MEM.
- `mem_wb_en`, output, 1: write-back enable in MEM.
- `wb_dest`, output, REG_ADDR_LEN: destination in WB.
- `wb_wb_en`, output, 1: write-back enable in WB.
- `state`, output, 2: status; 0=RUN, 1=STALL, 2=FROZEN, 3=FLUSH.
- `stall_count`, output, STALL_CNT_LEN: total hazard-stall cycles; saturates.
- `deadlock`, output, 1: sticky watchdog flag.

## Operation
- Priority at each rising `clk` edge: `rst` > `mem_freeze` > `branch_taken` > `hazard` > normal.
- Reset:
  - All stage registers go to 0 (dest = 0, wb_en = 0).
  - `stall_count` = 0, `deadlock` = 0, `state` = RUN, run counter = 0.
- `mem_freeze` = 1:
  - All stage registers, counters and the run counter hold.
  - `state` = FROZEN.
- Otherwise the pipeline advances: WB ← MEM, MEM ← EXE. EXE loads as follows.
  - `branch_taken` = 1: bubble (dest = 0, wb_en = 0). `state` = FLUSH. Run counter is cleared. `hazard` is ignored this cycle.
  - `hazard` = 1: bubble. `state` = STALL. `stall_count` +1, saturating at all-ones. Run counter +1.
  - Else: `exe_dest` ← `id_dest`, `exe_wb_en` ← `id_wb_en & id_valid`. `state` = RUN. Run counter is cleared.
- Watchdog: if the run counter would exceed `MAX_STALL`, `deadlock` is set. It stays set until `rst`.
- Combinational outputs:
  - `pc_freeze` = `if_id_freeze` = `mem_freeze | (hazard & ~branch_taken)`.
  - `if_id_flush` = `branch_taken & ~mem_freeze`.
- A bubble never carries a stale destination: dest is forced to 0 along with wb_en.

## Timing
- Registered stage outputs are valid one cycle after the controlling edge.
- An instruction in ID at edge N appears on `exe_*` after N, on `mem_*` after N+1, and on `wb_*` after N+2. Each stall or freeze cycle adds one cycle to this.
- Hazard at edge N gives a bubble on `exe_*` in cycle N+1. The same ID instruction re-enters on the first edge where `hazard` is low.
- Freeze/flush outputs are combinational, zero latency, and have no reset dependency.
- `rst` asserted mid-stall or mid-freeze clears everything on that edge. `deadlock` also clears.
- `branch_taken` together with `mem_freeze`: the freeze wins, nothing moves, and `if_id_flush` = 0. The flush takes effect on the first unfrozen edge, provided `branch_taken` is still held.
- `stall_count` at all-ones stays at all-ones.

## Test plan
- Reset, then three consecutive ID instructions (dest 3/5/7, wb_en 1):
  - `exe_dest` reads 3, 5, 7 on successive cycles.
  - `mem_dest` trails by one cycle and `wb_dest` by two.
  - `stall_count` stays 0.
- `hazard` high for 2 cycles while ID holds dest 9:
  - `exe_wb_en` = 0 for 2 cycles, then `exe_dest` = 9.
  - `pc_freeze` is high exactly 2 cycles.
  - `stall_count` = 2; `deadlock` = 0.
- `hazard` high for 3 cycles with MAX_STALL = 2: `deadlock` = 1 after the third edge, and it stays 1 until `rst`.
- `mem_freeze` high for 4 cycles with the pipeline full (EXE/MEM/WB = 4/6/8):
  - All stage outputs hold 4/6/8.
  - `state` = 2 throughout.
  - `stall_count` is unchanged.
- `branch_taken` and `hazard` high together:
  - `if_id_flush` = 1 and `pc_freeze` = 0.
  - Bubble in EXE; `stall_count` is unchanged; `state` = 3.
- Preload `stall_count` to near-saturation (STALL_CNT_LEN = 4, 15 stalls spaced by RUN cycles), then one more stall: count stays 15, and `rst` returns it to 0.
